// File: rtl/terrain_collider_multi.sv
`default_nettype none
// ============================================================================
// terrain_collider_multi
// Per-object terrain and screen-wall collision flags gathered over one frame.
// Revision: 1.0
// ============================================================================
module terrain_collider_multi #(
    parameter int N_OBJ    = 4,
    parameter int COL_H    = 512,
    parameter int SCREEN_W = 640,
    parameter int COORD_W  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COL_H-1:0]         terrain_data,
    input  logic [COORD_W-1:0]       DrawX,
    input  logic                     col_valid,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic [N_OBJ*COORD_W-1:0] obj_x,
    input  logic [N_OBJ*COORD_W-1:0] obj_y,
    input  logic [N_OBJ*COORD_W-1:0] obj_r,
    output logic [N_OBJ-1:0]         landed,
    output logic [N_OBJ-1:0]         bounce,
    output logic [N_OBJ-1:0]         hit_left,
    output logic [N_OBJ-1:0]         hit_right,
    output logic                     result_valid
);
    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_scan   = 2'd1;
    localparam logic [1:0] c_report = 2'd2;
    localparam logic [COORD_W:0] c_col_h    = (COORD_W+1)'(COL_H);
    localparam logic [COORD_W:0] c_screen_w = (COORD_W+1)'(SCREEN_W);

    logic [1:0]               state_q, state_d;
    logic [N_OBJ*COORD_W-1:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d, obj_r_q, obj_r_d;
    logic [N_OBJ-1:0]         land_acc_q, land_acc_d, bnc_acc_q, bnc_acc_d;
    logic [N_OBJ-1:0]         left_acc_q, left_acc_d, right_acc_q, right_acc_d;
    logic [N_OBJ-1:0]         landed_q, landed_d, bounce_q, bounce_d;
    logic [N_OBJ-1:0]         hit_left_q, hit_left_d, hit_right_q, hit_right_d;
    logic                     result_valid_q, result_valid_d;

    logic [N_OBJ-1:0] w_land_set, w_bnc_set, w_left_set, w_right_set;
    logic [N_OBJ-1:0] w_floor, w_ceil, w_lwall, w_rwall;
    logic [COORD_W:0] w_drawx;

    assign w_drawx = {1'b0, DrawX};

    // Out-of-range rows read as empty: the shift runs off the column.
    function automatic logic bit_at(input logic [COL_H-1:0] data,
                                    input logic [COORD_W:0] idx);
        logic [COL_H-1:0] shifted;
        shifted = data >> idx;
        return shifted[0];
    endfunction

    generate
        for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
            logic [COORD_W:0] w_x, w_y, w_r, w_x_plus_r, w_x_minus_r, w_y_plus_r, w_y_minus_r;
            assign w_x         = {1'b0, obj_x_q[i*COORD_W +: COORD_W]};
            assign w_y         = {1'b0, obj_y_q[i*COORD_W +: COORD_W]};
            assign w_r         = {1'b0, obj_r_q[i*COORD_W +: COORD_W]};
            assign w_x_plus_r  = w_x + w_r;
            assign w_x_minus_r = w_x - w_r;
            assign w_y_plus_r  = w_y + w_r;
            assign w_y_minus_r = w_y - w_r;

            assign w_floor[i] = (w_y_plus_r >= c_col_h);
            assign w_ceil[i]  = (w_y < w_r);
            assign w_lwall[i] = (w_x < w_r);
            assign w_rwall[i] = (w_x_plus_r >= c_screen_w);

            assign w_land_set[i]  = (w_drawx == w_x) && !w_floor[i] && bit_at(terrain_data, w_y_plus_r);
            assign w_bnc_set[i]   = (w_drawx == w_x) && !w_ceil[i] && bit_at(terrain_data, w_y_minus_r);
            assign w_left_set[i]  = (w_drawx == w_x_minus_r) && !w_lwall[i] && (w_y < c_col_h)
                                    && bit_at(terrain_data, w_y);
            assign w_right_set[i] = (w_drawx == w_x_plus_r) && !w_rwall[i] && (w_y < c_col_h)
                                    && bit_at(terrain_data, w_y);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= c_idle;
            obj_x_q        <= '0;
            obj_y_q        <= '0;
            obj_r_q        <= '0;
            land_acc_q     <= '0;
            bnc_acc_q      <= '0;
            left_acc_q     <= '0;
            right_acc_q    <= '0;
            landed_q       <= '0;
            bounce_q       <= '0;
            hit_left_q     <= '0;
            hit_right_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            obj_x_q        <= obj_x_d;
            obj_y_q        <= obj_y_d;
            obj_r_q        <= obj_r_d;
            land_acc_q     <= land_acc_d;
            bnc_acc_q      <= bnc_acc_d;
            left_acc_q     <= left_acc_d;
            right_acc_q    <= right_acc_d;
            landed_q       <= landed_d;
            bounce_q       <= bounce_d;
            hit_left_q     <= hit_left_d;
            hit_right_q    <= hit_right_d;
            result_valid_q <= result_valid_d;
        end
    end

    // frame_start overrides everything, including a coincident frame_end.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = c_scan;
        end else begin
            case (state_q)
                c_scan:   if (frame_end) state_d = c_report;
                c_report: state_d = c_idle;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        obj_x_d     = obj_x_q;
        obj_y_d     = obj_y_q;
        obj_r_d     = obj_r_q;
        land_acc_d  = land_acc_q;
        bnc_acc_d   = bnc_acc_q;
        left_acc_d  = left_acc_q;
        right_acc_d = right_acc_q;
        if (frame_start) begin
            obj_x_d     = obj_x;
            obj_y_d     = obj_y;
            obj_r_d     = obj_r;
            land_acc_d  = '0;
            bnc_acc_d   = '0;
            left_acc_d  = '0;
            right_acc_d = '0;
        end else if (state_q == c_scan && col_valid) begin
            land_acc_d  = land_acc_q  | w_land_set;
            bnc_acc_d   = bnc_acc_q   | w_bnc_set;
            left_acc_d  = left_acc_q  | w_left_set;
            right_acc_d = right_acc_q | w_right_set;
        end
    end

    always_comb begin
        landed_d       = landed_q;
        bounce_d       = bounce_q;
        hit_left_d     = hit_left_q;
        hit_right_d    = hit_right_q;
        result_valid_d = 1'b0;
        if (state_q == c_report) begin
            landed_d       = land_acc_q | w_floor;
            bounce_d       = (bnc_acc_q | w_ceil) & ~(land_acc_q | w_floor);
            hit_left_d     = left_acc_q | w_lwall;
            hit_right_d    = right_acc_q | w_rwall;
            result_valid_d = 1'b1;
        end
    end

    assign landed       = landed_q;
    assign bounce       = bounce_q;
    assign hit_left     = hit_left_q;
    assign hit_right    = hit_right_q;
    assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_terrain_collider_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_terrain_collider_multi
// Directed frame vectors plus restart and mid-scan reset sequences.
// Revision: 1.0
// ============================================================================
module tb_terrain_collider_multi;
    localparam int N_OBJ    = 4;
    localparam int COL_H    = 512;
    localparam int SCREEN_W = 640;
    localparam int COORD_W  = 10;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [COL_H-1:0]         terrain_data;
    logic [COORD_W-1:0]       DrawX;
    logic                     col_valid, frame_start, frame_end;
    logic [N_OBJ*COORD_W-1:0] obj_x, obj_y, obj_r;
    logic [N_OBJ-1:0]         landed, bounce, hit_left, hit_right;
    logic                     result_valid;

    int n_pass  = 0;
    int n_total = 0;

    terrain_collider_multi #(
        .N_OBJ(N_OBJ), .COL_H(COL_H), .SCREEN_W(SCREEN_W), .COORD_W(COORD_W)
    ) dut (
        .clk(clk), .reset(reset), .terrain_data(terrain_data), .DrawX(DrawX),
        .col_valid(col_valid), .frame_start(frame_start), .frame_end(frame_end),
        .obj_x(obj_x), .obj_y(obj_y), .obj_r(obj_r),
        .landed(landed), .bounce(bounce), .hit_left(hit_left), .hit_right(hit_right),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [39:0] ox, oy, orad;
        int          ncol;
        int          cx0, b0a, b0b, cx1, b1a, b1b;
        logic [3:0]  e_land, e_bnc, e_left, e_right;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_col(input int x, input int ba, input int bb);
        col_valid    = 1'b1;
        DrawX        = 10'(x);
        terrain_data = '0;
        if (ba >= 0) terrain_data[ba] = 1'b1;
        if (bb >= 0) terrain_data[bb] = 1'b1;
        tick();
        col_valid    = 1'b0;
        terrain_data = '0;
    endtask

    task automatic check_flags(input string name, input logic [3:0] l, input logic [3:0] b,
                               input logic [3:0] hl, input logic [3:0] hr);
        check({name, ".landed"},    int'(landed),    int'(l));
        check({name, ".bounce"},    int'(bounce),    int'(b));
        check({name, ".hit_left"},  int'(hit_left),  int'(hl));
        check({name, ".hit_right"}, int'(hit_right), int'(hr));
    endtask

    task automatic run_vec(input vec_t v);
        obj_x = v.ox; obj_y = v.oy; obj_r = v.orad;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        // Scramble the live inputs: only the snapshot may matter now.
        obj_x = ~v.ox; obj_y = ~v.oy; obj_r = ~v.orad;
        if (v.ncol > 0) apply_col(v.cx0, v.b0a, v.b0b);
        if (v.ncol > 1) apply_col(v.cx1, v.b1a, v.b1b);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check({v.name, ".rv_early"}, int'(result_valid), 0);
        tick();
        check({v.name, ".rv"}, int'(result_valid), 1);
        check_flags(v.name, v.e_land, v.e_bnc, v.e_left, v.e_right);
        tick();
        check({v.name, ".rv_drop"}, int'(result_valid), 0);
        check({v.name, ".hold"}, int'(landed), int'(v.e_land));
    endtask

    initial begin
        vecs[0] = '{"land", pk(100,600,600,600), pk(200,300,300,300), pk(8,4,4,4),
                    1, 100, 208, -1, 0, -1, -1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[1] = '{"land_over_bounce", pk(100,600,600,600), pk(200,300,300,300), pk(8,4,4,4),
                    1, 100, 192, 208, 0, -1, -1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[2] = '{"bounce", pk(100,600,600,600), pk(200,300,300,300), pk(8,4,4,4),
                    1, 100, 192, -1, 0, -1, -1, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[3] = '{"lwall_floor", pk(600,5,200,600), pk(300,100,508,300), pk(4,8,8,4),
                    0, 0, -1, -1, 0, -1, -1, 4'b0100, 4'b0000, 4'b0010, 4'b0000};
        vecs[4] = '{"side_left", pk(600,600,600,300), pk(300,300,300,50), pk(4,4,4,4),
                    2, 296, 50, -1, 304, -1, -1, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        vecs[5] = '{"side_right", pk(600,600,600,300), pk(300,300,300,50), pk(4,4,4,4),
                    2, 304, 50, -1, 300, 54, -1, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
        vecs[6] = '{"ceil_rwall", pk(50,635,400,600), pk(3,100,510,300), pk(8,8,4,4),
                    0, 0, -1, -1, 0, -1, -1, 4'b0100, 4'b0001, 4'b0000, 4'b0010};
        vecs[7] = '{"ceil_vs_land", pk(50,300,600,600), pk(3,600,300,300), pk(8,4,4,4),
                    1, 50, 11, -1, 0, -1, -1, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        vecs[8] = '{"sticky", pk(100,600,600,600), pk(200,300,300,300), pk(8,4,4,4),
                    2, 100, 208, -1, 100, -1, -1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

        reset = 1'b1; terrain_data = '0; DrawX = '0; col_valid = 1'b0;
        frame_start = 1'b0; frame_end = 1'b0; obj_x = '0; obj_y = '0; obj_r = '0;
        tick(); tick();
        check("reset.rv", int'(result_valid), 0);
        check_flags("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Restart: coincident start/end discards the frame and gives no report.
        obj_x = vecs[0].ox; obj_y = vecs[0].oy; obj_r = vecs[0].orad;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        apply_col(100, 208, -1);
        frame_start = 1'b1; frame_end = 1'b1;
        tick();
        frame_start = 1'b0; frame_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("restart.no_rv", int'(result_valid), 0);
            tick();
        end
        check_flags("restart.hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("restart.rv", int'(result_valid), 1);
        check_flags("restart.cleared", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();

        // Asynchronous reset in the middle of a scan.
        run_vec(vecs[0]);
        obj_x = vecs[0].ox; obj_y = vecs[0].oy; obj_r = vecs[0].orad;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        apply_col(100, 208, -1);
        #2 reset = 1'b1;
        #1;
        check("midreset.rv", int'(result_valid), 0);
        check_flags("midreset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("midreset.no_rv", int'(result_valid), 0);
            tick();
        end
        check("midreset.landed", int'(landed), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
